// File: rtl/fir_pkg.sv
// Shared FIR constants plus the accumulator-width and saturation helpers
// used by the output quantizer and its bench model.
package fir_pkg;

   localparam int unsigned WIDTH  = 16;
   localparam int unsigned LENGTH = 100;

   typedef struct packed {
      logic signed [63:0] val;
      logic               sat;
   } clip_t;

   function automatic int unsigned fir_acc_width(input int unsigned w, input int unsigned l);
      return 32'($clog2(l)) + 2 * w;
   endfunction

   // Clip a signed value to an ow-bit two's complement range; sat marks clipping.
   function automatic clip_t sat_clip(input logic signed [63:0] x, input int unsigned ow);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      clip_t              r;
      hi    = (64'sd1 <<< (ow - 1)) - 64'sd1;
      lo    = -(64'sd1 <<< (ow - 1));
      r.val = x;
      r.sat = 1'b0;
      if (x > hi) begin
         r.val = hi;
         r.sat = 1'b1;
      end else if (x < lo) begin
         r.val = lo;
         r.sat = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO: registered storage, combinational head read,
// extra-MSB pointers so full/empty fall straight out of the pointer compare.
module sync_fifo #(
   parameter int unsigned W     = 17,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]  wr_q, wr_d;
   logic [AW:0]  rd_q, rd_d;
   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];
   logic         do_pop_c;
   logic         do_push_c;

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign dout  = mem_q[rd_q[AW-1:0]];

   // A push into a full FIFO is only accepted when the head leaves on the same edge.
   always_comb begin
      do_pop_c  = pop & ~empty;
      do_push_c = push & (~full | do_pop_c);
      mem_d     = mem_q;
      wr_d      = wr_q;
      rd_d      = rd_q;
      if (do_push_c) begin
         mem_d[wr_q[AW-1:0]] = din;
         wr_d                = wr_q + (AW+1)'(1);
      end
      if (do_pop_c) begin
         rd_d = rd_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/fir_output_quantizer.sv
// FIR output stage: half-up round and shift, saturate to OUT_WIDTH, buffer in a
// FIFO behind valid/ready. Overflow drops samples and counts them; never stalls.
module fir_output_quantizer
   import fir_pkg::*;
#(
   parameter int unsigned IN_WIDTH  = fir_acc_width(WIDTH, LENGTH),
   parameter int unsigned OUT_WIDTH = 16,
   parameter int unsigned SHIFT     = 16,
   parameter int unsigned DEPTH     = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [IN_WIDTH-1:0]  in_data,
   input  logic                 in_valid,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_sat,
   output logic                 out_valid,
   input  logic                 out_ready,
   input  logic                 clr_status,
   output logic                 overflow,
   output logic [7:0]           drop_count
);

   localparam logic signed [IN_WIDTH:0] HALF = (IN_WIDTH+1)'(1) << (SHIFT - 1);

   logic                        v1_q, v1_d;
   logic signed [IN_WIDTH:0]    r1_q, r1_d;
   logic                        v2_q, v2_d;
   logic [OUT_WIDTH-1:0]        d2_q, d2_d;
   logic                        sat2_q, sat2_d;
   logic                        overflow_q, overflow_d;
   logic [7:0]                  drop_cnt_q, drop_cnt_d;
   logic signed [IN_WIDTH:0]    ext_c;
   logic                        pop_c;
   logic                        drop_c;
   logic                        full_c;
   logic                        empty_c;

   assign out_valid  = ~empty_c;
   assign pop_c      = out_valid & out_ready;
   assign drop_c     = v2_q & full_c & ~pop_c;
   assign overflow   = overflow_q;
   assign drop_count = drop_cnt_q;

   // One guard bit keeps the rounding add from wrapping at the positive extreme.
   always_comb begin
      ext_c = {in_data[IN_WIDTH-1], in_data};
      v1_d  = in_valid;
      r1_d  = r1_q;
      if (in_valid) begin
         r1_d = (ext_c + HALF) >>> SHIFT;
      end
      v2_d             = v1_q;
      {d2_d, sat2_d}   = (OUT_WIDTH+1)'(sat_clip(64'(r1_q), OUT_WIDTH));
   end

   // A drop on the same edge as a clear wins, leaving a count of one.
   always_comb begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      if (clr_status) begin
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end
      if (drop_c) begin
         overflow_d = 1'b1;
         if (drop_cnt_d != 8'hff) begin
            drop_cnt_d = drop_cnt_d + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1_q       <= 1'b0;
         r1_q       <= '0;
         v2_q       <= 1'b0;
         d2_q       <= '0;
         sat2_q     <= 1'b0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         v1_q       <= v1_d;
         r1_q       <= r1_d;
         v2_q       <= v2_d;
         d2_q       <= d2_d;
         sat2_q     <= sat2_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   sync_fifo #(
      .W     (OUT_WIDTH + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (v2_q),
      .pop   (pop_c),
      .din   ({sat2_q, d2_q}),
      .dout  ({out_sat, out_data}),
      .full  (full_c),
      .empty (empty_c)
   );

endmodule

// File: tb/tb_fir_output_quantizer.sv
// Scoreboard bench for fir_output_quantizer at default parameters.
module tb_fir_output_quantizer;
   import fir_pkg::*;

   logic               clk;
   logic               reset;
   logic signed [38:0] in_data;
   logic               in_valid;
   logic [15:0]        out_data;
   logic               out_sat;
   logic               out_valid;
   logic               out_ready;
   logic               clr_status;
   logic               overflow;
   logic [7:0]         drop_count;

   int                 n_total = 0;
   int                 n_bad   = 0;
   logic [16:0]        sb_q [$];

   fir_output_quantizer dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .out_data   (out_data),
      .out_sat    (out_sat),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .clr_status (clr_status),
      .overflow   (overflow),
      .drop_count (drop_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected {sat,data}: half-up round at bit 16, then clip to 16 bits.
   function automatic logic [16:0] model(input logic signed [38:0] x);
      logic signed [63:0] r;
      clip_t              c;
      r = (64'(x) + 64'sd32768) >>> 16;
      c = sat_clip(r, 16);
      return {c.sat, c.val[15:0]};
   endfunction

   // Drive one in_valid cycle; caller deasserts in_valid when the burst ends.
   task automatic send(input logic signed [38:0] v, input logic [16:0] e, input bit keep);
      in_data  = v;
      in_valid = 1'b1;
      if (keep) sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain;
      int n;
      n = 0;
      while ((sb_q.size() != 0 || out_valid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", 64'(sb_q.size()), 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, 64'(out_valid), 0);
      chk({tag, "_data"}, 64'(out_data), 0);
      chk({tag, "_sat"}, 64'(out_sat), 0);
      chk({tag, "_ovf"}, 64'(overflow), 0);
      chk({tag, "_drops"}, 64'(drop_count), 0);
   endtask

   // Scoreboard: compare the head on every cycle it is accepted.
   always @(negedge clk) begin
      logic [16:0] e;
      if (reset && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_out", 64'(out_valid), 0);
         end else begin
            e = sb_q.pop_front();
            chk("out_data", 64'(out_data), 64'(e[15:0]));
            chk("out_sat", 64'(out_sat), 64'(e[16]));
         end
      end
   end

   initial begin
      int lat;
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b0;
      clr_status = 1'b0;
      reset      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("por");
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // 1.5 in Q16 rounds to 2; out_valid three cycles after in_valid
      out_ready = 1'b1;
      send(39'sd98304, 17'h00002, 1'b1);
      in_valid = 1'b0;
      lat = 1;
      forever begin
         @(negedge clk);
         if (out_valid || lat > 10) break;
         lat++;
      end
      chk("latency", 64'(lat), 3);
      wait_drain();

      // Half-up rounding around zero
      send(-39'sd32768, 17'h00000, 1'b1);
      send(-39'sd98304, 17'h0ffff, 1'b1);
      send(39'sd32768, 17'h00001, 1'b1);
      send(-39'sd32769, 17'h0ffff, 1'b1);
      in_valid = 1'b0;
      wait_drain();

      // Saturation edges; exact minimum is not flagged
      send(39'sd2147483648, 17'h17fff, 1'b1);
      send(-39'sd2147483648, 17'h08000, 1'b1);
      send(-39'sd2147549184, 17'h18000, 1'b1);
      in_valid = 1'b0;
      wait_drain();

      // Overflow: six back-to-back into a stalled four-entry FIFO
      out_ready = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         send(39'(i * 65536), model(39'(i * 65536)), i <= 4);
      end
      in_valid = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      chk("ovf_flag", 64'(overflow), 1);
      chk("ovf_count", 64'(drop_count), 2);
      chk("ovf_head", 64'(out_data), 1);
      out_ready = 1'b1;
      wait_drain();

      // Full FIFO with push and pop on the same edge
      out_ready = 1'b0;
      for (int i = 7; i <= 10; i++) begin
         send(39'(i * 65536), model(39'(i * 65536)), 1'b1);
      end
      in_valid = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      send(39'(11 * 65536), model(39'(11 * 65536)), 1'b1);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("pp_count", 64'(drop_count), 2);
      chk("pp_valid", 64'(out_valid), 1);
      wait_drain();
      clr_status = 1'b1;
      @(posedge clk);
      #1;
      clr_status = 1'b0;
      chk("clr_ovf", 64'(overflow), 0);
      chk("clr_count", 64'(drop_count), 0);

      // Clear coinciding with a drop: the drop wins
      out_ready = 1'b0;
      for (int i = 20; i <= 23; i++) begin
         send(39'(i * 65536), model(39'(i * 65536)), 1'b1);
      end
      in_valid = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      send(39'(24 * 65536), model(39'(24 * 65536)), 1'b0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      clr_status = 1'b1;
      @(posedge clk);
      #1;
      clr_status = 1'b0;
      chk("clrdrop_ovf", 64'(overflow), 1);
      chk("clrdrop_count", 64'(drop_count), 1);
      out_ready = 1'b1;
      wait_drain();

      // Reset with two samples in flight and three buffered
      out_ready = 1'b0;
      for (int i = 30; i <= 34; i++) begin
         send(39'(i * 65536), model(39'(i * 65536)), 1'b1);
      end
      in_valid = 1'b0;
      chk("pre_rst_valid", 64'(out_valid), 1);
      chk("pre_rst_head", 64'(out_data), 30);
      #2;
      reset = 1'b0;
      #1;
      chk_reset_vals("mid");
      sb_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(39'(5 * 65536), model(39'(5 * 65536)), 1'b1);
      in_valid = 1'b0;
      wait_drain();
      repeat (6) @(negedge clk);
      chk("post_rst_idle", 64'(out_valid), 0);
      chk("post_rst_ovf", 64'(overflow), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
